// File: rtl/elevator_request_scheduler_if.sv
// rtl/elevator_request_scheduler_if.sv - call/position inputs and target/status outputs of the scheduler
interface elevator_request_scheduler_if #(
  parameter int NUM_FLOORS = 6
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [3:0]            current_floor;
  logic                  car_idle;
  logic [3:0]            target_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  door_open;
  logic                  dir_up;
  logic                  busy;

  modport master (
    output call_req, current_floor, car_idle,
    input  target_floor, pending, door_open, dir_up, busy
  );

  modport slave (
    input  call_req, current_floor, car_idle,
    output target_floor, pending, door_open, dir_up, busy
  );
endinterface

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - sweep-order elevator call scheduler with door dwell
// Optional feature ELEV_RETARGET_EN: retarget to a closer pending floor on the way during MOVE.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 6,
  parameter int DWELL_CYCLES = 8
) (
  input logic                        clk,
  input logic                        rst,
  elevator_request_scheduler_if.slave bus
);
  localparam int             CW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]  DWELL_LOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
  logic [3:0]            r_target, w_target_nxt;
  logic                  r_dir_up, w_dir_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;

  logic                  w_floor_ok;
  logic [NUM_FLOORS-1:0] w_cur_onehot, w_tgt_onehot;
  logic [NUM_FLOORS-1:0] w_clr, w_call_mask;
  logic                  w_cur_pend, w_dwell_call, w_do_sel;
  logic                  w_up_hit, w_dn_hit;
  logic [3:0]            w_up_floor, w_dn_floor;
  state_t                w_sel_state;
  logic [3:0]            w_sel_target;
  logic                  w_sel_dir;

  assign w_floor_ok = (int'(bus.current_floor) < NUM_FLOORS);

  // Nearest pending floor strictly above / strictly below the car.
  always_comb begin
    w_cur_onehot = '0;
    w_tgt_onehot = '0;
    w_up_hit     = 1'b0;
    w_up_floor   = '0;
    w_dn_hit     = 1'b0;
    w_dn_floor   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_cur_onehot[i] = (int'(bus.current_floor) == i);
      w_tgt_onehot[i] = (int'(r_target) == i);
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(bus.current_floor))) begin
        w_up_hit   = 1'b1;
        w_up_floor = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && (i < int'(bus.current_floor))) begin
        w_dn_hit   = 1'b1;
        w_dn_floor = 4'(i);
      end
    end
  end

  assign w_cur_pend   = |(r_pending & w_cur_onehot);
  assign w_dwell_call = |(bus.call_req & w_tgt_onehot);

  always_comb begin
    w_sel_state  = S_IDLE;
    w_sel_target = bus.current_floor;
    w_sel_dir    = r_dir_up;
    if (w_cur_pend) begin
      w_sel_state = S_DWELL;
    end else if (r_dir_up && w_up_hit) begin
      w_sel_state  = S_MOVE;
      w_sel_target = w_up_floor;
    end else if (!r_dir_up && w_dn_hit) begin
      w_sel_state  = S_MOVE;
      w_sel_target = w_dn_floor;
    end else if (r_dir_up && w_dn_hit) begin
      w_sel_state  = S_MOVE;
      w_sel_target = w_dn_floor;
      w_sel_dir    = 1'b0;
    end else if (!r_dir_up && w_up_hit) begin
      w_sel_state  = S_MOVE;
      w_sel_target = w_up_floor;
      w_sel_dir    = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_dir_nxt    = r_dir_up;
    w_cnt_nxt    = r_cnt;
    w_clr        = '0;
    w_call_mask  = '0;
    w_do_sel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_do_sel = w_floor_ok;
      end
      S_MOVE: begin
        if (w_floor_ok) begin
          if ((bus.current_floor == r_target) && bus.car_idle) begin
            w_state_nxt = S_DWELL;
            w_cnt_nxt   = DWELL_LOAD;
            w_clr       = w_tgt_onehot;
          end
`ifdef ELEV_RETARGET_EN
          else if (r_dir_up && w_up_hit && (w_up_floor < r_target)) begin
            w_target_nxt = w_up_floor;
          end else if (!r_dir_up && w_dn_hit && (w_dn_floor > r_target)) begin
            w_target_nxt = w_dn_floor;
          end
`endif
        end
      end
      S_DWELL: begin
        // A call at the open floor never becomes pending; it just holds the door.
        w_call_mask = w_tgt_onehot;
        if (w_floor_ok) begin
          if (w_dwell_call) begin
            w_cnt_nxt = DWELL_LOAD;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            w_do_sel = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_do_sel) begin
      w_state_nxt  = w_sel_state;
      w_target_nxt = w_sel_target;
      w_dir_nxt    = w_sel_dir;
      if (w_sel_state == S_DWELL) begin
        w_cnt_nxt = DWELL_LOAD;
        w_clr     = w_cur_onehot;
      end
    end
  end

  assign w_pending_nxt = (r_pending | (bus.call_req & ~w_call_mask)) & ~w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_target  <= '0;
      r_dir_up  <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_target  <= w_target_nxt;
      r_dir_up  <= w_dir_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign bus.target_floor = r_target;
  assign bus.pending      = r_pending;
  assign bus.door_open    = (r_state == S_DWELL);
  assign bus.dir_up       = r_dir_up;
  assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - scoreboarded bench for elevator_request_scheduler
module tb_elevator_request_scheduler;
  localparam int NF = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  elevator_request_scheduler_if #(.NUM_FLOORS(NF)) bus ();

  elevator_request_scheduler #(
    .NUM_FLOORS  (NF),
    .DWELL_CYCLES(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple car: one floor per cycle toward target_floor while the scheduler is moving.
  task automatic drive_car();
    if (bus.busy && !bus.door_open && (bus.current_floor != bus.target_floor)) begin
      if (bus.current_floor < bus.target_floor) bus.current_floor = bus.current_floor + 4'd1;
      else bus.current_floor = bus.current_floor - 4'd1;
      bus.car_idle = (bus.current_floor == bus.target_floor);
    end else begin
      bus.car_idle = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.call_req = '0;
    bus.current_floor = 4'd0;
    bus.car_idle = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.target_floor !== 4'd0) begin n_errors++; $display("FAIL reset_target: got %0d expected 0", bus.target_floor); end
    n_checks++; if (bus.pending !== 6'b0) begin n_errors++; $display("FAIL reset_pending: got %b expected 000000", bus.pending); end
    n_checks++; if (bus.door_open !== 1'b0) begin n_errors++; $display("FAIL reset_door: got %b expected 0", bus.door_open); end
    n_checks++; if (bus.dir_up !== 1'b1) begin n_errors++; $display("FAIL reset_dir: got %b expected 1", bus.dir_up); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
  endtask

  task automatic test_service_order(input string name, input int budget);
    logic prev_door = 1'b0;
    int   doors = 0;
    int   stops = 0;
    logic done = 1'b0;
    logic [3:0] e;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (bus.door_open) doors++;
      if (bus.door_open && !prev_door) begin
        stops++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL %s_stop: door opened at floor %0d, expected no stop", name, bus.target_floor);
        end else begin
          e = exp_q.pop_front();
          if (bus.target_floor !== e) begin
            n_errors++;
            $display("FAIL %s_stop: got floor %0d expected %0d", name, bus.target_floor, e);
          end
        end
      end
      prev_door = bus.door_open;
      if ((exp_q.size() == 0) && !bus.busy) done = 1'b1;
      else drive_car();
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL %s_timeout: got %0d stops left expected 0", name, exp_q.size()); end
    n_checks++; if (doors !== DW * stops) begin n_errors++; $display("FAIL %s_dwell: got %0d door cycles expected %0d", name, doors, DW * stops); end
    n_checks++; if (bus.pending !== 6'b0) begin n_errors++; $display("FAIL %s_pending: got %b expected 000000", name, bus.pending); end
    exp_q.delete();
  endtask

  task automatic test_single_call();
    bus.call_req = 6'b001000;
    tick();
    bus.call_req = '0;
    n_checks++; if (bus.pending !== 6'b001000) begin n_errors++; $display("FAIL single_pending: got %b expected 001000", bus.pending); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_n1: got %b expected 0", bus.busy); end
    tick();
    n_checks++; if (bus.target_floor !== 4'd3) begin n_errors++; $display("FAIL single_target: got %0d expected 3", bus.target_floor); end
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_n2: got %b expected 1", bus.busy); end
    exp_q.push_back(4'd3);
  endtask

  task automatic test_sweep();
    bus.current_floor = 4'd2;
    tick();
    bus.call_req = 6'b010010;
    tick();
    bus.call_req = '0;
    n_checks++; if (bus.pending !== 6'b010010) begin n_errors++; $display("FAIL sweep_pending: got %b expected 010010", bus.pending); end
    tick();
    n_checks++; if (bus.target_floor !== 4'd4) begin n_errors++; $display("FAIL sweep_target: got %0d expected 4", bus.target_floor); end
    n_checks++; if (bus.dir_up !== 1'b1) begin n_errors++; $display("FAIL sweep_dir: got %b expected 1", bus.dir_up); end
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd1);
  endtask

  task automatic test_direction_reversal();
    n_checks++; if (bus.dir_up !== 1'b0) begin n_errors++; $display("FAIL reversal_dir: got %b expected 0", bus.dir_up); end
    n_checks++; if (bus.target_floor !== 4'd1) begin n_errors++; $display("FAIL reversal_hold: got %0d expected 1", bus.target_floor); end
  endtask

  task automatic test_dwell_extend();
    int held = 0;
    bus.current_floor = 4'd3;
    tick();
    bus.call_req = 6'b001000;
    tick();
    bus.call_req = '0;
    tick();
    n_checks++; if (bus.door_open !== 1'b1) begin n_errors++; $display("FAIL extend_open: got %b expected 1", bus.door_open); end
    repeat (5) tick();
    bus.call_req = 6'b001000;
    tick();
    bus.call_req = '0;
    n_checks++; if (bus.pending[3] !== 1'b0) begin n_errors++; $display("FAIL extend_pending: got %b expected 0", bus.pending[3]); end
    for (int c = 0; c < 30; c++) begin
      if (!bus.door_open) break;
      held++;
      tick();
    end
    n_checks++; if (held !== DW) begin n_errors++; $display("FAIL extend_hold: got %0d cycles expected %0d", held, DW); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL extend_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_same_floor();
    bus.current_floor = 4'd0;
    tick();
    bus.call_req = 6'b000001;
    tick();
    bus.call_req = '0;
    n_checks++; if (bus.pending !== 6'b000001) begin n_errors++; $display("FAIL same_pending: got %b expected 000001", bus.pending); end
    exp_q.push_back(4'd0);
  endtask

  task automatic test_invalid_floor();
    bus.current_floor = 4'd9;
    tick();
    bus.call_req = 6'b010000;
    tick();
    bus.call_req = '0;
    n_checks++; if (bus.pending !== 6'b010000) begin n_errors++; $display("FAIL invalid_pending: got %b expected 010000", bus.pending); end
    repeat (3) tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL invalid_hold_state: got %b expected 0", bus.busy); end
    n_checks++; if (bus.target_floor !== 4'd0) begin n_errors++; $display("FAIL invalid_hold_target: got %0d expected 0", bus.target_floor); end
    bus.current_floor = 4'd2;
    tick();
    n_checks++; if (bus.target_floor !== 4'd4) begin n_errors++; $display("FAIL invalid_resume: got %0d expected 4", bus.target_floor); end
    exp_q.push_back(4'd4);
  endtask

  task automatic test_retarget();
    logic [3:0] exp_tgt;
`ifdef ELEV_RETARGET_EN
    exp_tgt = 4'd2;
`else
    exp_tgt = 4'd5;
`endif
    bus.current_floor = 4'd0;
    tick();
    bus.call_req = 6'b100000;
    tick();
    bus.call_req = '0;
    tick();
    n_checks++; if (bus.target_floor !== 4'd5) begin n_errors++; $display("FAIL retarget_initial: got %0d expected 5", bus.target_floor); end
    bus.current_floor = 4'd1;
    bus.car_idle = 1'b0;
    tick();
    bus.call_req = 6'b000100;
    tick();
    bus.call_req = '0;
    tick();
    n_checks++; if (bus.target_floor !== exp_tgt) begin n_errors++; $display("FAIL retarget_target: got %0d expected %0d", bus.target_floor, exp_tgt); end
    n_checks++; if (bus.pending[5] !== 1'b1) begin n_errors++; $display("FAIL retarget_keep5: got %b expected 1", bus.pending[5]); end
    if (exp_tgt == 4'd2) begin
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd5);
    end else begin
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd2);
    end
  endtask

  task automatic test_reset_mid_move();
    bus.current_floor = 4'd0;
    bus.car_idle = 1'b1;
    tick();
    bus.call_req = 6'b100000;
    tick();
    bus.call_req = '0;
    tick();
    bus.current_floor = 4'd2;
    bus.car_idle = 1'b0;
    tick();
    bus.call_req = 6'b000010;
    tick();
    bus.call_req = '0;
    n_checks++; if (bus.pending !== 6'b100010) begin n_errors++; $display("FAIL midmove_pending: got %b expected 100010", bus.pending); end
    n_checks++; if (bus.target_floor !== 4'd5) begin n_errors++; $display("FAIL midmove_target: got %0d expected 5", bus.target_floor); end
    rst = 1'b1;
    bus.call_req = 6'b001000;
    tick();
    n_checks++; if (bus.target_floor !== 4'd0) begin n_errors++; $display("FAIL midrst_target: got %0d expected 0", bus.target_floor); end
    n_checks++; if (bus.pending !== 6'b0) begin n_errors++; $display("FAIL midrst_pending: got %b expected 000000", bus.pending); end
    n_checks++; if (bus.door_open !== 1'b0) begin n_errors++; $display("FAIL midrst_door: got %b expected 0", bus.door_open); end
    n_checks++; if (bus.dir_up !== 1'b1) begin n_errors++; $display("FAIL midrst_dir: got %b expected 1", bus.dir_up); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    bus.call_req = '0;
    tick();
    n_checks++; if (bus.pending !== 6'b0) begin n_errors++; $display("FAIL rst_call_ignored: got %b expected 000000", bus.pending); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_service_order("single", 100);
    test_sweep();
    test_service_order("sweep", 200);
    test_direction_reversal();
    test_dwell_extend();
    test_same_floor();
    test_service_order("same_floor", 100);
    test_invalid_floor();
    test_service_order("invalid", 100);
    test_retarget();
    test_service_order("retarget", 200);
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 6, number of served floors (0..NUM_FLOORS-1, NUM_FLOORS <= 16).
REQ-002 Parameter DWELL_CYCLES, default 8, door-open dwell length in clk cycles (>= 1).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 call_req  input  NUM_FLOORS  per-floor call buttons, level-sampled each cycle, several may be high at once.
REQ-006 current_floor  input  4  car position from the elevator state machine.
REQ-007 car_idle  input  1  elevator state machine idle indication (high = car not moving).
REQ-008 target_floor  output  4  floor the car shall travel to, drives the elevator requested_floor.
REQ-009 pending  output  NUM_FLOORS  latched outstanding requests.
REQ-010 door_open  output  1  high during dwell.
REQ-011 dir_up  output  1  sweep direction (1 = up, 0 = down).
REQ-012 busy  output  1  high in MOVE or DWELL.

Function
REQ-013 States: IDLE (no target), MOVE (target latched, car travelling), DWELL (door open at a floor).
REQ-014 pending[i] sets on the edge after any cycle with call_req[i]=1; it stays set until serviced.
REQ-015 Selection (evaluated in IDLE and at the final DWELL cycle): if pending at current_floor -> DWELL; else nearest pending floor strictly in dir_up direction; else reverse dir_up and take nearest pending floor in the new direction; else IDLE.
REQ-016 Latency: call_req[i] high in cycle N with scheduler IDLE -> pending[i]=1 at N+1, state MOVE with target_floor=i at N+2.
REQ-017 In IDLE and DWELL, target_floor SHALL equal current_floor so the car holds position.
REQ-018 Arrival: in MOVE, current_floor==target_floor and car_idle=1 -> next edge enters DWELL and clears pending[target_floor].
REQ-019 door_open SHALL be high for exactly DWELL_CYCLES cycles per DWELL entry, via a down-counter loaded with DWELL_CYCLES-1.
REQ-020 Simultaneous call_req[i] and clear of pending[i] (arrival or DWELL at floor i): clear wins, and in DWELL the dwell counter reloads (door held open).
REQ-021 call_req at the DWELL floor during DWELL SHALL not set pending and SHALL reload the dwell counter.
REQ-022 current_floor >= NUM_FLOORS: state, target_floor and dir_up SHALL hold; pending still accepts calls.
REQ-023 busy = (state != IDLE); dir_up changes only at a selection point.

Reset
REQ-024 rst=1 at a rising edge -> state IDLE, pending=0, target_floor=0, door_open=0, dir_up=1, busy=0, dwell counter=0, regardless of state (including mid-MOVE or mid-DWELL).
REQ-025 Calls asserted during reset SHALL be ignored; the first sampled cycle is the first with rst=0.

Configuration
REQ-026 Macro ELEV_RETARGET_EN: when defined, in MOVE a newly pending floor strictly between current_floor and target_floor in the dir_up direction replaces target_floor on the next edge, and the old target stays pending; when undefined, target_floor is fixed from MOVE entry until arrival.

Verification
REQ-027 Reset, current_floor=0, call_req[3] pulsed 1 cycle -> pending=6'b001000 at N+1, target_floor=3, busy=1 at N+2; after current_floor=3 and car_idle=1 -> door_open high 8 cycles, pending=0, then IDLE.
REQ-028 Car at 2 going up, pending floors 1 and 4 -> target 4 first, dir_up=1; after dwell -> dir_up=0, target 1.
REQ-029 DWELL at floor 3, call_req[3] pulsed at dwell cycle 5 -> door_open stays high 8 further cycles, pending[3]=0.
REQ-030 call_req[0] while current_floor=0 in IDLE -> DWELL directly, target_floor stays 0, door_open high 8 cycles.
REQ-031 rst asserted mid-MOVE toward 5 with pending 5 and 1 -> next cycle all outputs at reset values, target_floor=0.
REQ-032 With ELEV_RETARGET_EN: MOVE 0->5, call_req[2] while current_floor=1 -> target_floor=2 next edge, pending[5] stays 1; without it target_floor stays 5.
